// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle between issue, the sequential ALU and writeback
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             err;
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, zero, carry, overflow, negative, err
  );
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, zero, carry, overflow, negative, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with persistent flags and an iterative shift-add multiply
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_SLL = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
                         OP_ADC = 4'h8, OP_SBB = 4'h9, OP_MUL = 4'hA, OP_CMP = 4'hB;
  typedef enum logic {IDLE, MUL} state_t;
  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   mb_q, mb_d, out_q, out_d;
  logic [2*WIDTH-1:0] mc_q, mc_d, acc_q, acc_d, prod;
  logic               ov_q, ov_d, z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d, err_q, err_d;
  logic [WIDTH:0]     sum, diff, shl, shr;
  logic [WIDTH-1:0]   sra, res, fres;
  logic [SHW-1:0]     sh;
  logic               cin, add_v, sub_v, rc, rv, rerr;
  logic               slot_free, in_ready, accept, last;
  assign slot_free = !ov_q || bus.out_ready;
  assign in_ready  = state_q == IDLE && slot_free;
  assign accept    = bus.in_valid && in_ready;
  assign last      = cnt_q == SHW'(WIDTH - 1);
  assign prod      = acc_q + (mb_q[0] ? mc_q : '0);
  always_comb begin
    cin   = (bus.op == OP_ADC || bus.op == OP_SBB) && c_q;
    sh    = bus.b[SHW-1:0];
    sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
    diff  = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};
    shl   = {1'b0, bus.a} << sh;
    shr   = {bus.a, 1'b0} >> sh;
    sra   = $signed(bus.a) >>> sh;
    add_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    sub_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    res   = '0;
    rc    = 1'b0;
    rv    = 1'b0;
    rerr  = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin res = sum[WIDTH-1:0]; rc = sum[WIDTH]; rv = add_v; end
      OP_SUB, OP_SBB: begin res = diff[WIDTH-1:0]; rc = diff[WIDTH]; rv = sub_v; end
      OP_CMP:         begin res = bus.a; rc = diff[WIDTH]; rv = sub_v; end
      OP_AND:         res = bus.a & bus.b;
      OP_OR:          res = bus.a | bus.b;
      OP_XOR:         res = bus.a ^ bus.b;
      OP_SLL:         begin res = shl[WIDTH-1:0]; rc = shl[WIDTH]; end
      OP_SRL:         begin res = shr[WIDTH:1]; rc = shr[0]; end
      OP_SRA:         begin res = sra; rc = shr[0]; end
      OP_MUL:         ;
      default:        rerr = 1'b1;
    endcase
    fres = bus.op == OP_CMP ? diff[WIDTH-1:0] : res;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mb_d    = mb_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    err_d   = err_q;
    ov_d    = ov_q && !bus.out_ready;
    if (accept && bus.op == OP_MUL) begin
      state_d = MUL;
      cnt_d   = '0;
      mb_d    = bus.b;
      mc_d    = {{WIDTH{1'b0}}, bus.a};
      acc_d   = '0;
    end else if (accept) begin
      out_d = res;
      z_d   = fres == '0;
      n_d   = fres[WIDTH-1];
      c_d   = rc;
      v_d   = rv;
      err_d = rerr;
      ov_d  = 1'b1;
    end else if (state_q == MUL && (!last || slot_free)) begin
      acc_d = prod;
      mb_d  = mb_q >> 1;
      mc_d  = mc_q << 1;
      cnt_d = cnt_q + SHW'(1);
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = prod[WIDTH-1:0];
        z_d     = prod[WIDTH-1:0] == '0;
        n_d     = prod[WIDTH-1];
        c_d     = |prod[2*WIDTH-1:WIDTH];
        v_d     = 1'b0;
        err_d   = 1'b0;
        ov_d    = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mb_q    <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mb_q    <= mb_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.out       = out_q;
  assign bus.zero      = z_q;
  assign bus.carry     = c_q;
  assign bus.overflow  = v_q;
  assign bus.negative  = n_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, directed multi-cycle sequences and randomized traffic against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 16;
  typedef struct packed {logic [W-1:0] out; logic z, c, v, n, e;} res_t;
  typedef struct {string name; logic [3:0] op; logic [W-1:0] a, b; res_t exp;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_fail = 0;
  vec_t tbl[$];
  res_t exp_q[$];
  bit model_c, hold, ok;
  res_t saved;
  int lat;
  bit rdy_seen;
  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic res_t cur();
    return {bus.out, bus.zero, bus.carry, bus.overflow, bus.negative, bus.err};
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic vec_t mk(input string nm, input logic [3:0] op, input logic [W-1:0] a, b,
                              input logic [W-1:0] o, input bit z, c, v, n, e);
    vec_t t;
    t.name = nm; t.op = op; t.a = a; t.b = b; t.exp = {o, z, c, v, n, e};
    return t;
  endfunction
  function automatic res_t model(input logic [3:0] op, input int a, input int b, input bit cin);
    int mask = (1 << W) - 1;
    int s = b % W;
    int sa = a >= (1 << (W - 1)) ? a - (1 << W) : a;
    int r = 0, d = 0, f, c = 0, v = 0, e = 0;
    longint p;
    case (op)
      4'h0, 4'h8: begin
        r = a + b + ((op == 4'h8) ? int'(cin) : 0);
        c = int'(r > mask);
        r = r & mask;
        v = int'(((a >> (W-1)) == (b >> (W-1))) && ((r >> (W-1)) != (a >> (W-1))));
      end
      4'h1, 4'h9, 4'hB: begin
        d = a - b - ((op == 4'h9) ? int'(cin) : 0);
        c = int'(d < 0);
        d = d & mask;
        v = int'(((a >> (W-1)) != (b >> (W-1))) && ((d >> (W-1)) != (a >> (W-1))));
        r = (op == 4'hB) ? a : d;
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: begin r = (a << s) & mask; c = s == 0 ? 0 : (a >> (W - s)) & 1; end
      4'h6: begin r = a >> s; c = s == 0 ? 0 : (a >> (s - 1)) & 1; end
      4'h7: begin r = (sa >>> s) & mask; c = s == 0 ? 0 : (a >> (s - 1)) & 1; end
      4'hA: begin p = longint'(a) * longint'(b); r = int'(p & longint'(mask)); c = int'((p >> W) != 0); end
      default: e = 1;
    endcase
    f = (op == 4'hB) ? d : r;
    return {r[W-1:0], f == 0, c[0], v[0], f[W-1], e[0]};
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("issue_accepted", {31'd0, ok}, 32'd1);
  endtask
  task automatic wait_valid();
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("result_arrives", {31'd0, bus.out_valid}, 32'd1);
  endtask
  task automatic rnd_cycle(input bit drive);
    bit acc;
    res_t r;
    @(negedge clk);
    if (hold) check("rnd_hold", {bus.out_valid, cur()}, {1'b1, saved});
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("rnd_unexpected", 32'd1, 32'd0);
      else check("rnd_result", cur(), exp_q.pop_front());
    end
    hold = bus.out_valid && !bus.out_ready;
    saved = cur();
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      r = model(bus.op, int'(bus.a), int'(bus.b), model_c);
      exp_q.push_back(r);
      model_c = r.c;
    end
    @(posedge clk); #1;
    if (!drive) begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
    end else begin
      if (acc || !bus.in_valid) begin
        bus.in_valid = $urandom_range(0, 3) != 0;
        bus.op = 4'($urandom_range(0, 15));
        bus.a = pick();
        bus.b = pick();
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl.push_back(mk("add_ffff_1", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0, 0));
    tbl.push_back(mk("adc_chain",  4'h8, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sub_ovf",    4'h1, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, 0, 0));
    tbl.push_back(mk("cmp_lt",     4'hB, 16'h0003, 16'h0005, 16'h0003, 0, 1, 0, 1, 0));
    tbl.push_back(mk("cmp_eq",     4'hB, 16'h0007, 16'h0007, 16'h0007, 1, 0, 0, 0, 0));
    tbl.push_back(mk("sra_4",      4'h7, 16'h8000, 16'h0004, 16'hF800, 0, 0, 0, 1, 0));
    tbl.push_back(mk("sll_1",      4'h5, 16'h8001, 16'h0001, 16'h0002, 0, 1, 0, 0, 0));
    tbl.push_back(mk("srl_0",      4'h6, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 0, 0));
    tbl.push_back(mk("and",        4'h2, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("or",         4'h3, 16'hF000, 16'h000F, 16'hF00F, 0, 0, 0, 1, 0));
    tbl.push_back(mk("xor_self",   4'h4, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 0));
    tbl.push_back(mk("mul_ffff",   4'hA, 16'h00FF, 16'h0101, 16'hFFFF, 0, 0, 0, 1, 0));
    tbl.push_back(mk("mul_hi",     4'hA, 16'h1000, 16'h0010, 16'h0000, 1, 1, 0, 0, 0));
    tbl.push_back(mk("illegal_e",  4'hE, 16'h1234, 16'h0005, 16'h0000, 1, 0, 0, 0, 1));
    tbl.push_back(mk("add_ovf",    4'h0, 16'h8000, 16'h8000, 16'h0000, 1, 1, 1, 0, 0));
    tbl.push_back(mk("sbb_cin",    4'h9, 16'h0005, 16'h0003, 16'h0001, 0, 0, 0, 0, 0));
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", cur(), '0);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_valid();
      check(tbl[i].name, cur(), tbl[i].exp);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1; bus.op = 4'h0; bus.a = 16'hFFFF; bus.b = 16'h0001;
    @(posedge clk); #1;
    bus.op = 4'h8; bus.a = 16'h0000; bus.b = 16'h0000;
    @(negedge clk);
    check("b2b_add", cur(), {16'h0000, 5'b11000});
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_adc", {bus.out_valid, cur()}, {1'b1, 16'h0001, 5'b00000});
    @(posedge clk); #1;
    issue(4'hA, 16'h00FF, 16'h0101);
    lat = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      if (!bus.out_valid) begin
        rdy_seen |= bus.in_ready;
        @(posedge clk);
        lat++;
      end
    end while (!bus.out_valid && lat < 60);
    check("mul_latency", lat, 16);
    check("mul_in_ready_low", {31'd0, rdy_seen}, 32'd0);
    check("mul_result", cur(), {16'hFFFF, 5'b00010});
    @(posedge clk); #1;
    issue(4'hA, 16'h00FF, 16'h0101);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("rst_mid_mul_flags", cur(), '0);
    check("rst_mid_mul_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_mul_ready", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    issue(4'h0, 16'h0001, 16'h0001);
    wait_valid();
    check("post_reset_add_lat", lat, 0);
    check("post_reset_add", cur(), {16'h0002, 5'b00000});
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(4'h4, 16'h00FF, 16'h0F0F);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {bus.out_valid, bus.in_ready, cur()}, {2'b10, 16'h0FF0, 5'b00000});
    end
    bus.in_valid = 1'b1; bus.op = 4'h2; bus.a = 16'hFF00; bus.b = 16'h0FF0;
    bus.out_ready = 1'b1;
    #1;
    check("drain_refill_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.op = 4'hE; bus.a = 16'h1234; bus.b = 16'h0005;
    @(negedge clk);
    check("refill_and", {bus.out_valid, cur()}, {1'b1, 16'h0F00, 5'b00000});
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("refill_illegal", {bus.out_valid, cur()}, {1'b1, 16'h0000, 5'b10001});
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_c = 1'b0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) rnd_cycle(1'b1);
    for (int cyc = 0; cyc < 60; cyc++) rnd_cycle(1'b0);
    check("rnd_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
